// File: rtl/pusch_symbol_scheduler.sv
// ---------------------------------------------------------------------------
// pusch_symbol_scheduler
//
// Slot-level sequencer for the PUSCH transmit chain. A start pulse in IDLE
// latches the slot configuration. The configuration is validated for one
// cycle. The allocated OFDM symbols are then issued one at a time as
// descriptors to the RE mapper / IFFT. Each descriptor carries the absolute
// symbol index, the DMRS flag, the hop-adjusted start subcarrier and the
// allocation width in subcarriers. After each issued symbol the sequencer
// waits for the IFFT completion pulse before it issues the next one.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   enable        in   start pulse, sampled only in IDLE
//   N_symbol      in   [3:0]  allocated symbol count (1..14)
//   Sym_Start_REM in   [3:0]  first allocated symbol index (0..13)
//   N_rb          in   [6:0]  allocated resource blocks (1..100)
//   N_sc_start    in   [10:0] first-hop start subcarrier
//   En_hopping    in   [1:0]  0 none, 1 intra-slot, 2 inter-slot, 3 as none
//   N_slot_frame  in   [3:0]  slot number; bit0 picks the inter-slot hop
//   mod_ready     in   modulator holds one data symbol of samples
//   sym_ready     in   mapper accepts the descriptor
//   ifft_done     in   one-cycle pulse, IFFT finished the current symbol
//   busy          out  slot in progress (LOAD through SLOT_DONE)
//   sym_valid     out  descriptor valid, held until sym_ready
//   sym_idx       out  [3:0]  absolute symbol index
//   sym_is_dmrs   out  symbol carries DMRS
//   sym_sc_start  out  [10:0] start subcarrier for this symbol
//   sym_n_sc      out  [10:0] allocation width, N_rb*12
//   slot_done     out  one-cycle pulse after the last symbol completes
//   cfg_err       out  one-cycle pulse on a rejected configuration
// ---------------------------------------------------------------------------
module pusch_symbol_scheduler #(
  parameter int unsigned BWP_SC        = 1200,
  parameter int unsigned HOP_OFFSET_SC = 600,
  parameter int unsigned SYMS_PER_SLOT = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  N_symbol,
  input  logic [3:0]  Sym_Start_REM,
  input  logic [6:0]  N_rb,
  input  logic [10:0] N_sc_start,
  input  logic [1:0]  En_hopping,
  input  logic [3:0]  N_slot_frame,
  input  logic        mod_ready,
  input  logic        sym_ready,
  input  logic        ifft_done,
  output logic        busy,
  output logic        sym_valid,
  output logic [3:0]  sym_idx,
  output logic        sym_is_dmrs,
  output logic [10:0] sym_sc_start,
  output logic [10:0] sym_n_sc,
  output logic        slot_done,
  output logic        cfg_err
);

  localparam logic [11:0] BWP      = 12'(BWP_SC);
  localparam logic [11:0] HOP_OFF  = 12'(HOP_OFFSET_SC);
  localparam logic [4:0]  SYMS     = 5'(SYMS_PER_SLOT);
  localparam logic [4:0]  LAST_SYM = 5'(SYMS_PER_SLOT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_SLOT_DONE
  } state_e;

  state_e state_q;

  // Latched slot configuration
  logic [3:0]  nsym_q;
  logic [3:0]  start_q;
  logic [6:0]  nrb_q;
  logic [10:0] sc1_q;
  logic [1:0]  hop_mode_q;
  logic        slot_lsb_q;

  // Values derived once per slot in LOAD
  logic [3:0]  h1_q;
  logic [10:0] sc2_q;
  logic [10:0] nsc_q;
  logic [3:0]  rel_q;

  // Registered outputs
  logic        busy_q;
  logic        sym_valid_q;
  logic [3:0]  sym_idx_q;
  logic        sym_is_dmrs_q;
  logic [10:0] sym_sc_start_q;
  logic [10:0] sym_n_sc_q;
  logic        slot_done_q;
  logic        cfg_err_q;

  // Only the parity of the slot number matters for inter-slot hopping.
  logic unused_slot_bits;
  assign unused_slot_bits = ^N_slot_frame[3:1];

  // Config check on the latched values; the start+count sum is 5 bits wide
  // so 13+15 cannot alias into range.
  logic [4:0] nsym_ext;
  logic [4:0] start_ext;
  logic [4:0] span_sum;
  logic       cfg_bad;

  assign nsym_ext  = {1'b0, nsym_q};
  assign start_ext = {1'b0, start_q};
  assign span_sum  = start_ext + nsym_ext;
  assign cfg_bad   = (nsym_q == 4'd0) || (nsym_ext > SYMS) ||
                     (start_ext > LAST_SYM) || (span_sum > SYMS) ||
                     (nrb_q == 7'd0);

  // Second-hop start subcarrier, wrapped once into the bandwidth part.
  logic [11:0] sc2_sum;
  logic [11:0] sc2_wrap;
  logic [10:0] sc2_d;

  assign sc2_sum  = {1'b0, sc1_q} + HOP_OFF;
  assign sc2_wrap = (sc2_sum >= BWP) ? (sc2_sum - BWP) : sc2_sum;
  assign sc2_d    = sc2_wrap[10:0];

  // N_rb*12 as 8*N_rb + 4*N_rb.
  logic [10:0] nsc_d;
  assign nsc_d = 11'({nrb_q, 3'b000}) + 11'({nrb_q, 2'b00});

  logic intra_hop;
  logic inter_hop;
  assign intra_hop = (hop_mode_q == 2'd1);
  assign inter_hop = (hop_mode_q == 2'd2);

  logic hop2_d;
  logic dmrs_d;
  logic issue_ok;
  logic last_sym;

  // NOTE: every combinational output gets a default before the branches so
  // that no path leaves it unassigned and infers a latch.
  always_comb begin
    hop2_d = 1'b0;
    if (intra_hop) begin
      hop2_d = (rel_q >= h1_q) && (h1_q != 4'd0);
    end else if (inter_hop) begin
      hop2_d = slot_lsb_q;
    end
  end

  // DMRS symbols carry no modulator data, so they never wait on mod_ready.
  assign dmrs_d   = (rel_q == 4'd0) ||
                    (intra_hop && (h1_q != 4'd0) && (rel_q == h1_q));
  assign issue_ok = dmrs_d || mod_ready;
  assign last_sym = (rel_q == (nsym_q - 4'd1));

  // NOTE: all state here uses non-blocking assignments, and the asynchronous
  // reset clears every register including the descriptor fields so outputs
  // read 0 immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      nsym_q         <= '0;
      start_q        <= '0;
      nrb_q          <= '0;
      sc1_q          <= '0;
      hop_mode_q     <= '0;
      slot_lsb_q     <= 1'b0;
      h1_q           <= '0;
      sc2_q          <= '0;
      nsc_q          <= '0;
      rel_q          <= '0;
      busy_q         <= 1'b0;
      sym_valid_q    <= 1'b0;
      sym_idx_q      <= '0;
      sym_is_dmrs_q  <= 1'b0;
      sym_sc_start_q <= '0;
      sym_n_sc_q     <= '0;
      slot_done_q    <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      // Pulses default low; the states that fire them override below.
      slot_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            nsym_q     <= N_symbol;
            start_q    <= Sym_Start_REM;
            nrb_q      <= N_rb;
            sc1_q      <= N_sc_start;
            hop_mode_q <= En_hopping;
            slot_lsb_q <= N_slot_frame[0];
            busy_q     <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (cfg_bad) begin
            cfg_err_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            rel_q   <= '0;
            h1_q    <= nsym_q >> 1;
            sc2_q   <= sc2_d;
            nsc_q   <= nsc_d;
            state_q <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (sym_valid_q) begin
            // Descriptor is frozen until the mapper takes it.
            if (sym_ready) begin
              sym_valid_q <= 1'b0;
              state_q     <= ST_WAIT_DONE;
            end
          end else if (issue_ok) begin
            sym_valid_q    <= 1'b1;
            sym_idx_q      <= start_q + rel_q;
            sym_is_dmrs_q  <= dmrs_d;
            sym_sc_start_q <= hop2_d ? sc2_q : sc1_q;
            sym_n_sc_q     <= nsc_q;
          end
        end

        ST_WAIT_DONE: begin
          if (ifft_done) begin
            if (last_sym) begin
              slot_done_q <= 1'b1;
              state_q     <= ST_SLOT_DONE;
            end else begin
              rel_q   <= rel_q + 4'd1;
              state_q <= ST_ISSUE;
            end
          end
        end

        ST_SLOT_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q      <= 1'b0;
          sym_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign sym_valid    = sym_valid_q;
  assign sym_idx      = sym_idx_q;
  assign sym_is_dmrs  = sym_is_dmrs_q;
  assign sym_sc_start = sym_sc_start_q;
  assign sym_n_sc     = sym_n_sc_q;
  assign slot_done    = slot_done_q;
  assign cfg_err      = cfg_err_q;

endmodule
